// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the memory-access stage.
//
// Each access is arbitrated in IDLE. The winner's command is latched there,
// and the access then runs through a request/response handshake
// (ISSUE -> [WAIT] -> RESP). The module also raises a stall request while
// either requester is waiting for its ack.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. Without it, data has fixed priority over fetch.

module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,

   // Fetch port (read only)
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,

   // Data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,

   // Memory command/response
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,

   // Hazard-unit stall request
   output logic              stall_req
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   typedef enum logic [1:0] {
      GrNone,
      GrFetch,
      GrData
   } grant_e;

   state_e              state_q,     state_d;
   grant_e              grant_q,     grant_d;
   logic                cmd_we_q,    cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
   grant_e              winner;

`ifdef MEM_ARB_RR_EN
   grant_e              last_grant_q, last_grant_d;
`endif

   // Pick the requester to serve if IDLE grants this cycle.
   always_comb begin
      winner = GrNone;
`ifdef MEM_ARB_RR_EN
      // On a tie, the requester served less recently wins.
      if (if_req && d_req) begin
         winner = (last_grant_q == GrData) ? GrFetch : GrData;
      end else if (d_req) begin
         winner = GrData;
      end else if (if_req) begin
         winner = GrFetch;
      end
`else
      if (d_req) begin
         winner = GrData;
      end else if (if_req) begin
         winner = GrFetch;
      end
`endif
   end

   // Next state and next values of the latched command and read-data registers.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif

      unique case (state_q)
         StIdle: begin
            // Request inputs are sampled only here; later changes are ignored.
            if (winner != GrNone) begin
               grant_d = winner;
               state_d = StIssue;
`ifdef MEM_ARB_RR_EN
               last_grant_d = winner;
`endif
               if (winner == GrData) begin
                  cmd_we_d    = d_we;
                  cmd_addr_d  = d_addr;
                  cmd_wdata_d = d_wdata;
               end else begin
                  cmd_we_d    = 1'b0;
                  cmd_addr_d  = if_addr;
                  cmd_wdata_d = '0;
               end
            end
         end

         StIssue: begin
            // The command stays on the bus unchanged until the memory accepts it.
            if (mem_ready) begin
               state_d = cmd_we_q ? StResp : StWait;
            end
         end

         StWait: begin
            if (mem_rvalid) begin
               if (grant_q == GrData) begin
                  d_rdata_d = mem_rdata;
               end else begin
                  if_rdata_d = mem_rdata;
               end
               state_d = StResp;
            end
         end

         StResp: begin
            state_d = StIdle;
            grant_d = GrNone;
         end

         default: begin
            state_d = StIdle;
            grant_d = GrNone;
         end
      endcase
   end

   // State and datapath registers. An asynchronous reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         grant_q     <= GrNone;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember the most recent grant. Reset points it at fetch, so data wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= GrFetch;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Memory command outputs come straight from the latched command.
   always_comb begin
      mem_valid = (state_q == StIssue);
      mem_we    = mem_valid & cmd_we_q;
      mem_addr  = cmd_addr_q;
      mem_wdata = cmd_wdata_q;
   end

   // Requester outputs. The ack pulses in RESP, and read data holds between acks.
   always_comb begin
      if_ack   = (state_q == StResp) && (grant_q == GrFetch);
      d_ack    = (state_q == StResp) && (grant_q == GrData);
      if_rdata = if_rdata_q;
      d_rdata  = d_rdata_q;
   end

   // Stall while a request waits for its ack. Forced low while reset is asserted.
   always_comb begin
      stall_req = reset & ((if_req & ~if_ack) | (d_req & ~d_ack));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// A transaction-level model checks every output on each falling edge.
// Directed sequences also carry literal expectations at key cycles.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req, if_ack;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req, d_we, d_ack;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata, d_rdata;
   logic              mem_valid, mem_we, mem_ready, mem_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              stall_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ack     (if_ack),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .stall_req  (stall_req)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: one access at a time, described by its progress flags.
   bit                model_on = 1'b0;
   bit                m_busy, m_data, m_we, m_issued, m_done, m_last_data;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_if_rdata, m_d_rdata;

   task automatic model_reset();
      m_busy      = 1'b0;
      m_data      = 1'b0;
      m_we        = 1'b0;
      m_issued    = 1'b0;
      m_done      = 1'b0;
      m_last_data = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_if_rdata  = '0;
      m_d_rdata   = '0;
   endtask

   initial model_reset();

   always @(negedge clk) begin
      if (model_on) begin
         if (!reset) begin
            model_reset();
            chk("rst_mem_valid", mem_valid, 0);
            chk("rst_mem_we",    mem_we,    0);
            chk("rst_mem_addr",  mem_addr,  0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_if_ack",    if_ack,    0);
            chk("rst_d_ack",     d_ack,     0);
            chk("rst_if_rdata",  if_rdata,  0);
            chk("rst_d_rdata",   d_rdata,   0);
            chk("rst_stall",     stall_req, 0);
         end else begin
            bit e_valid, e_ifack, e_dack, pick_data;
            e_valid = m_busy && !m_issued;
            e_ifack = m_busy && m_done && !m_data;
            e_dack  = m_busy && m_done && m_data;
            chk("mem_valid", mem_valid, e_valid);
            chk("mem_we",    mem_we,    e_valid && m_we);
            if (e_valid) chk("mem_addr", mem_addr, m_addr);
            if (e_valid && m_we) chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_ack",    if_ack,    e_ifack);
            chk("d_ack",     d_ack,     e_dack);
            chk("if_rdata",  if_rdata,  m_if_rdata);
            chk("d_rdata",   d_rdata,   m_d_rdata);
            chk("stall_req", stall_req, (if_req && !e_ifack) || (d_req && !e_dack));

            // Advance the model using the inputs the DUT samples at the next rising edge.
            if (!m_busy) begin
               if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                  pick_data = (if_req && d_req) ? !m_last_data : d_req;
`else
                  pick_data = d_req;
`endif
                  m_busy      = 1'b1;
                  m_issued    = 1'b0;
                  m_done      = 1'b0;
                  m_data      = pick_data;
                  m_last_data = pick_data;
                  m_we        = pick_data && d_we;
                  m_addr      = pick_data ? d_addr : if_addr;
                  m_wdata     = pick_data ? d_wdata : '0;
               end
            end else if (!m_issued) begin
               if (mem_ready) begin
                  m_issued = 1'b1;
                  m_done   = m_we;
               end
            end else if (!m_done) begin
               if (mem_rvalid) begin
                  if (m_data) m_d_rdata = mem_rdata;
                  else        m_if_rdata = mem_rdata;
                  m_done = 1'b1;
               end
            end else begin
               m_busy = 1'b0;
            end
         end
      end
   end

   // Advance to 1 time unit after the next rising edge; inputs are driven from there.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [ADDR_W-1:0] order [4];
   int                n_order;

   initial begin
      reset = 1'b1;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      #1 reset = 1'b0;
      model_on = 1'b1;

      // Reset held with both requests high: everything stays at zero.
      if_req = 1; if_addr = 32'h100;
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
      mem_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("lit_rst_valid", mem_valid, 0);
      chk("lit_rst_stall", stall_req, 0);
      chk("lit_rst_dack",  d_ack,     0);

      // Reset released: contention, data write first and then the fetch read.
      reset = 1'b1;
      #1 chk("lit_c0_stall", stall_req, 1);
      cyc();
      chk("lit_w_valid", mem_valid, 1);
      chk("lit_w_we",    mem_we,    1);
      chk("lit_w_addr",  mem_addr,  32'h2000);
      chk("lit_w_wdata", mem_wdata, 32'hDEADBEEF);
      cyc();
      chk("lit_w_dack",  d_ack,     1);
      chk("lit_w_ifack", if_ack,    0);
      chk("lit_w_stall", stall_req, 1);
      cyc(); d_req = 0;
      #1 chk("lit_idle_dack", d_ack, 0);
      cyc();
      chk("lit_f_valid", mem_valid, 1);
      chk("lit_f_addr",  mem_addr,  32'h100);
      cyc(); mem_rvalid = 1; mem_rdata = 32'h00500093;
      cyc(); mem_rvalid = 0; mem_rdata = 0;
      #1;
      chk("lit_f_ack",   if_ack,    1);
      chk("lit_f_rdata", if_rdata,  32'h00500093);
      chk("lit_f_stall", stall_req, 0);
      cyc(); if_req = 0;
      #1 chk("lit_f_hold", if_rdata, 32'h00500093);

      // Single fetch read on a zero-wait memory: ack 3 cycles after the request.
      cyc(); if_req = 1; if_addr = 32'h104;
      #1 chk("lit_f2_stall0", stall_req, 1);
      cyc(); chk("lit_f2_stall1", stall_req, 1);
      cyc(); mem_rvalid = 1; mem_rdata = 32'h00A00113;
      #1 chk("lit_f2_stall2", stall_req, 1);
      cyc(); mem_rvalid = 0;
      chk("lit_f2_ack", if_ack, 1);
      chk("lit_f2_rdata", if_rdata, 32'h00A00113);
      cyc(); if_req = 0;

      // Data read with mem_ready held low for 3 cycles.
      cyc(); d_req = 1; d_we = 0; d_addr = 32'h3000; mem_ready = 0;
      repeat (3) begin
         cyc();
         chk("lit_bp_valid", mem_valid, 1);
         chk("lit_bp_addr",  mem_addr,  32'h3000);
         chk("lit_bp_dack",  d_ack,     0);
      end
      cyc(); mem_ready = 1;
      cyc(); mem_rvalid = 1; mem_rdata = 32'h12345678;
      cyc(); mem_rvalid = 0;
      chk("lit_bp_ack",   d_ack,   1);
      chk("lit_bp_rdata", d_rdata, 32'h12345678);
      cyc(); d_req = 0;

      // Abort: reset pulsed while a fetch waits for read data; the late rvalid is dropped.
      cyc(); if_req = 1; if_addr = 32'h400;
      cyc();
      cyc(); reset = 0; if_req = 0;
      #1 chk("lit_ab_valid", mem_valid, 0);
      cyc(); reset = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
      repeat (3) begin
         cyc();
         chk("lit_ab_ack",   if_ack,   0);
         chk("lit_ab_rdata", if_rdata, 0);
      end
      mem_rvalid = 0;

      // Both requests held continuously; record the grant order by address.
      cyc();
      if_req = 1; if_addr = 32'h108;
      d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'h55AA;
      mem_rvalid = 1; mem_rdata = 32'h13;
      n_order = 0;
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (mem_valid && n_order < 4) begin
            order[n_order] = mem_addr;
            n_order++;
         end
      end
      if_req = 0; d_req = 0; mem_rvalid = 0;
      chk("lit_rr_count", n_order, 4);
`ifdef MEM_ARB_RR_EN
      chk("lit_rr_g0", order[0], 32'h2004);
      chk("lit_rr_g1", order[1], 32'h108);
      chk("lit_rr_g2", order[2], 32'h2004);
      chk("lit_rr_g3", order[3], 32'h108);
`else
      chk("lit_fp_g0", order[0], 32'h2004);
      chk("lit_fp_g1", order[1], 32'h2004);
      chk("lit_fp_g2", order[2], 32'h2004);
      chk("lit_fp_g3", order[3], 32'h2004);
`endif
      repeat (6) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
